fifo_serial_tx: RTL and testbench

//  Read-side consumer for the 4-bit FIFO: pops words through its enable/rnw port and

---
 rtl/fifo_serial_tx.sv | 157 +++++++++++++++
 tb/tb_fifo_serial_tx.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_serial_tx.sv
// fifo_serial_tx: pops 4-bit words from a FIFO and sends each as a UART frame.
// Ports: clk, rst (sync, active-low), tx_en, fifo_empty, fifo_out -> fifo_enable, fifo_rnw, tx, busy, words_sent.
module fifo_serial_tx #(
  parameter int DATA_W       = 4,
  parameter int CLKS_PER_BIT = 4,
  parameter int STOP_BITS    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tx_en,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_out,
  output logic              fifo_enable,
  output logic              fifo_rnw,
  output logic              tx,
  output logic              busy,
  output logic [7:0]        words_sent
);

  localparam int CNT_W =
    (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_MAX =
    (DATA_W > STOP_BITS) ? DATA_W : STOP_BITS;
  localparam int BIT_W =
    (BIT_MAX > 1) ? $clog2(BIT_MAX) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] DATA_LAST =
    BIT_W'(DATA_W - 1);
  localparam logic [BIT_W-1:0] STOP_LAST =
    BIT_W'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    LOAD,
    START,
    DATA,
    STOP
  } state_t;

  state_t            state;
  state_t            state_n;
  logic [CNT_W-1:0]  clk_cnt;
  logic [CNT_W-1:0]  clk_cnt_n;
  logic [BIT_W-1:0]  bit_cnt;
  logic [BIT_W-1:0]  bit_cnt_n;
  logic [DATA_W-1:0] shift;
  logic [DATA_W-1:0] shift_n;
  logic [7:0]        words_n;
  logic              fifo_enable_n;
  logic              tx_n;
  logic              busy_n;
  logic              bit_end;
  logic              start_ok;

  // The block only ever reads the FIFO.
  assign fifo_rnw = 1'b0;

  assign bit_end  = (clk_cnt == CNT_LAST);
  assign start_ok = tx_en && !fifo_empty;

  always_comb begin
    state_n   = state;
    clk_cnt_n = clk_cnt;
    bit_cnt_n = bit_cnt;
    shift_n   = shift;
    words_n   = words_sent;
    unique case (state)
      IDLE: begin
        if (start_ok) state_n = REQ;
      end
      REQ: begin
        state_n = LOAD;
      end
      LOAD: begin
        shift_n   = fifo_out;
        clk_cnt_n = '0;
        bit_cnt_n = '0;
        state_n   = START;
      end
      START: begin
        if (bit_end) begin
          clk_cnt_n = '0;
          state_n   = DATA;
        end else begin
          clk_cnt_n = clk_cnt + 1'b1;
        end
      end
      DATA: begin
        if (bit_end) begin
          clk_cnt_n = '0;
          shift_n   = shift >> 1;
          if (bit_cnt == DATA_LAST) begin
            bit_cnt_n = '0;
            state_n   = STOP;
          end else begin
            bit_cnt_n = bit_cnt + 1'b1;
          end
        end else begin
          clk_cnt_n = clk_cnt + 1'b1;
        end
      end
      STOP: begin
        if (bit_end) begin
          clk_cnt_n = '0;
          if (bit_cnt == STOP_LAST) begin
            bit_cnt_n = '0;
            words_n   = words_sent + 8'd1;
            state_n   = start_ok ? REQ : IDLE;
          end else begin
            bit_cnt_n = bit_cnt + 1'b1;
          end
        end else begin
          clk_cnt_n = clk_cnt + 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    // Outputs are decoded from the next state so the
    // registered pins line up with the state register.
    fifo_enable_n = (state_n == REQ);
    busy_n        = (state_n != IDLE);
    unique case (state_n)
      START:   tx_n = 1'b0;
      DATA:    tx_n = shift_n[0];
      default: tx_n = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      clk_cnt     <= '0;
      bit_cnt     <= '0;
      shift       <= '0;
      words_sent  <= 8'd0;
      fifo_enable <= 1'b0;
      tx          <= 1'b1;
      busy        <= 1'b0;
    end else begin
      state       <= state_n;
      clk_cnt     <= clk_cnt_n;
      bit_cnt     <= bit_cnt_n;
      shift       <= shift_n;
      words_sent  <= words_n;
      fifo_enable <= fifo_enable_n;
      tx          <= tx_n;
      busy        <= busy_n;
    end
  end

endmodule

// File: tb/tb_fifo_serial_tx.sv
// tb_fifo_serial_tx: directed bench for fifo_serial_tx with a FIFO model.
// Drives tx_en/rst, feeds words, decodes tx at mid-bit and checks counters.
module tb_fifo_serial_tx;

  logic       clk;
  logic       rst;
  logic       tx_en;
  logic       fifo_empty;
  logic [3:0] fifo_out;
  logic       fifo_enable;
  logic       fifo_rnw;
  logic       tx;
  logic       busy;
  logic [7:0] words_sent;

  int checks   = 0;
  int failures = 0;

  logic [3:0] mem [0:511];
  int wr_ptr = 0;
  int rd_ptr = 0;
  int pops   = 0;
  int viol   = 0;
  int cyc    = 0;

  fifo_serial_tx dut (
    .clk         (clk),
    .rst         (rst),
    .tx_en       (tx_en),
    .fifo_empty  (fifo_empty),
    .fifo_out    (fifo_out),
    .fifo_enable (fifo_enable),
    .fifo_rnw    (fifo_rnw),
    .tx          (tx),
    .busy        (busy),
    .words_sent  (words_sent)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign fifo_empty = (wr_ptr == rd_ptr);

  initial fifo_out = 4'h0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (fifo_enable === 1'b1 && fifo_rnw === 1'b0) begin
      if (fifo_empty) viol <= viol + 1;
      else begin
        fifo_out <= mem[rd_ptr];
        rd_ptr   <= rd_ptr + 1;
      end
      pops <= pops + 1;
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic push(input logic [3:0] v);
    mem[wr_ptr] = v;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic wait_en(input string tag,
                         output bit ok,
                         output int t);
    ok = 1'b0;
    t  = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (fifo_enable === 1'b1) begin
        ok = 1'b1;
        t  = cyc;
        break;
      end
    end
    if (!ok) chk({tag, "_pop_timeout"}, 32'(fifo_enable), 1);
  endtask

  // Returns at the 24th negedge after the pop strobe was seen.
  task automatic do_frame(input string tag,
                          input logic [3:0] exp,
                          input bit drop,
                          output int t);
    bit ok;
    logic [3:0] d;
    wait_en(tag, ok, t);
    if (!ok) return;
    chk({tag, "_busy"}, 32'(busy), 1);
    @(negedge clk);
    chk({tag, "_pulse1"}, 32'(fifo_enable), 0);
    repeat (3) @(negedge clk);
    chk({tag, "_start"}, 32'(tx), 0);
    for (int k = 0; k < 4; k++) begin
      repeat (4) @(negedge clk);
      d[k] = tx;
      if (drop && k == 1) tx_en = 1'b0;
    end
    repeat (4) @(negedge clk);
    chk({tag, "_stop"}, 32'(tx), 1);
    chk({tag, "_data"}, 32'(d), 32'(exp));
  endtask

  initial begin
    int t;
    int tprev;
    int p0;
    int bad;
    bit ok;
    bit seen255;

    // 1: reset
    rst   = 1'b0;
    tx_en = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_tx", 32'(tx), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_en", 32'(fifo_enable), 0);
    chk("rst_rnw", 32'(fifo_rnw), 0);
    chk("rst_words", 32'(words_sent), 0);
    rst = 1'b1;

    // 2: single word 0xA
    tx_en = 1'b1;
    push(4'hA);
    do_frame("one", 4'hA, 1'b0, t);
    repeat (2) @(negedge clk);
    chk("one_busy_end", 32'(busy), 0);
    chk("one_words", 32'(words_sent), 1);
    chk("one_tx_idle", 32'(tx), 1);

    // 3: eight words back to back
    tx_en = 1'b0;
    rst   = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 8; i++) push(4'(i));
    tx_en = 1'b1;
    tprev = 0;
    for (int i = 0; i < 8; i++) begin
      do_frame($sformatf("burst%0d", i), 4'(i), 1'b0, t);
      if (i > 0) chk($sformatf("burst%0d_gap", i), 32'(t - tprev), 26);
      tprev = t;
    end
    repeat (2) @(negedge clk);
    chk("burst_words", 32'(words_sent), 8);
    chk("burst_idle", 32'(busy), 0);
    chk("burst_pops", 32'(pops), 9);

    // 4: empty FIFO with tx_en high
    bad = 0;
    p0  = pops;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (fifo_enable !== 1'b0 || tx !== 1'b1 || busy !== 1'b0)
        bad++;
    end
    chk("empty_bad_cycles", 32'(bad), 0);
    chk("empty_pops", 32'(pops - p0), 0);

    // 5: tx_en drops during data of word 3
    tx_en = 1'b0;
    push(4'h6);
    push(4'h5);
    push(4'h9);
    push(4'h3);
    p0    = pops;
    tx_en = 1'b1;
    do_frame("drop1", 4'h6, 1'b0, t);
    do_frame("drop2", 4'h5, 1'b0, t);
    do_frame("drop3", 4'h9, 1'b1, t);
    repeat (2) @(negedge clk);
    chk("drop_busy", 32'(busy), 0);
    repeat (60) @(negedge clk);
    chk("drop_pops", 32'(pops - p0), 3);
    chk("drop_left", 32'(fifo_empty), 0);
    chk("drop_words", 32'(words_sent), 11);

    // 6: reset during data bit 2 of word 0x3
    tx_en = 1'b1;
    wait_en("midrst", ok, t);
    repeat (15) @(negedge clk);
    chk("midrst_bit2", 32'(tx), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_tx", 32'(tx), 1);
    chk("midrst_words", 32'(words_sent), 0);
    chk("midrst_busy", 32'(busy), 0);
    rst = 1'b1;
    push(4'hE);
    do_frame("fresh", 4'hE, 1'b0, t);
    repeat (2) @(negedge clk);
    chk("fresh_words", 32'(words_sent), 1);

    // 6b: 256 frames wrap the counter
    tx_en = 1'b0;
    rst   = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 256; i++) push(4'(i * 7));
    p0      = pops;
    seen255 = 1'b0;
    tx_en   = 1'b1;
    for (int i = 0; i < 7000; i++) begin
      @(negedge clk);
      if (words_sent == 8'd255) seen255 = 1'b1;
      if (seen255 && !busy && fifo_empty) break;
    end
    chk("wrap_seen255", 32'(seen255), 1);
    chk("wrap_words", 32'(words_sent), 0);
    chk("wrap_pops", 32'(pops - p0), 256);
    chk("wrap_idle", 32'(busy), 0);

    chk("no_pop_while_empty", 32'(viol), 0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
